store_buffer: RTL and testbench
===============================

# store_buffer

Posted-store queue between the pipelined core's MEM stage and the byte-addressed data memory. It accepts stores in one cycle and holds them in a FIFO, then drains them to the memory's single shared port in cycles when no load needs that port. Loads that overlap a pending store are stalled until the conflicting stores have drained. The memory therefore always returns correct data without any forwarding logic.

## Interface
- WIDTH, 32, address/data width
- DEPTH, 4, entries; power of two, ≥2
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- st_valid  in  1  MEM-stage store request
- st_addr  in  WIDTH  store byte address
- st_data  in  WIDTH  store data, right-aligned
- st_mode  in  3  size code: 001 word; 010/100 half; 011/101 byte; others byte
- st_ready  out  1  entry available; push = st_valid & st_ready
- ld_valid  in  1  MEM-stage load request
- ld_addr  in  WIDTH  load byte address
- ld_mode  in  3  load size code, same encoding as st_mode
- ld_stall  out  1  hold load in MEM this cycle
- flush  in  1  fence: drain everything, accept nothing
- empty  out  1  no pending entries
- mem_we  out  1  memory write enable
- mem_addr  out  WIDTH  memory address (A)
- mem_wd  out  WIDTH  memory write data (WD)
- mem_mode  out  3  memory size code (modeAddr)

## Operation
- **Storage:** circular FIFO of DEPTH entries {addr, data, mode}, with head/tail pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- **st_ready:** count < DEPTH and !flush. It is a registered-state function and does not depend on a same-cycle pop.
- **Overlap:** computed on addr[16:0] with 18-bit arithmetic, no wrap.
  - Size per mode: 4, 2 or 1 bytes.
  - A load range [la, la+ls-1] hazards if it intersects any valid entry range [sa, sa+ss-1].
- **MMIO exemption:** a load with ld_addr == 0x100 never hazards; it is the trigger register.
- **hazard:** ld_valid & (overlap with any valid entry | flush) & !empty.
- **ld_stall:** equals hazard.
- **Drain:** drain = !empty & (!ld_valid | hazard). The head entry pops on the edge where drain = 1.
- **Memory port mux:**
  - drain = 1: mem_we = 1, mem_addr/mem_wd/mem_mode = head entry.
  - drain = 0: mem_we = 0, mem_addr = ld_addr, mem_mode = ld_mode, mem_wd = 0.
- **Push and pop in the same cycle:** count unchanged, both pointers advance.
- **st_valid & ld_valid together (illegal from the pipeline):** the push still occurs. The load is checked against existing entries only.
- **Ordering:** stores drain strictly in order. Repeated stores to the same address are not merged.
- **flush:** blocks pushes and forces drain every cycle until empty. empty = (count == 0).

## Timing
- **Reset values:** count, head and tail = 0; st_ready = 1; empty = 1; ld_stall = 0; mem_we = 0.
- **Push latency:** a pushed entry is visible for hazard checks and drain from the next cycle.
- **Minimum store latency:** one idle cycle after the push, the store is written to memory.
- **Combinational outputs:** ld_stall, mem_* and st_ready/empty are decoded in the same cycle from current state and inputs.
- **Load completion:** a stalled load completes in the first cycle its hazard clears; mem_addr = ld_addr that cycle.
- **Worst-case stall:** DEPTH cycles.
- **Full:** st_ready = 0 while count == DEPTH, including a cycle where a pop occurs. It rises in the cycle after the pop.
- **Reset mid-operation:** all pending stores are discarded and mem_we deasserts immediately (asynchronous reset).

## Configuration
- **STORE_BUFFER_STATS_EN defined:** adds the following outputs, both reset to 0:
  - stall_cnt, out, 32: counts cycles with ld_stall = 1; saturates at 0xFFFFFFFF.
  - drain_cnt, out, 32: counts drained entries; saturates at 0xFFFFFFFF.
- **Undefined:** neither port nor counter exists. Behaviour is otherwise identical.

## Test plan
- **Reset then push:** push word 0x11223344 @0x40 and idle one cycle → mem_we = 1, mem_addr = 0x40, mem_mode = 001. The following cycle empty = 1.
- **Fill:** push 4 stores with ld_valid held 1 at non-overlapping 0x200 → st_ready = 0 after the 4th push and ld_stall = 0 throughout. Then drop ld_valid → drains in order over 4 cycles.
- **Hazard:** pending byte store @0x43, then load word @0x40 → ld_stall = 1 and drain in the same cycle. Next cycle ld_stall = 0 and mem_addr = 0x40.
- **No hazard and MMIO exemption:**
  - Pending half @0x44, load byte @0x46 → ld_stall = 0.
  - Pending word @0xFE, load @0x100 → ld_stall = 0.
- **flush:** 3 pending entries with flush held → st_ready = 0, 3 consecutive mem_we pulses, then empty = 1. Any ld_valid during this period sees ld_stall = 1.
- **Async reset:** assert rst with 2 pending entries → mem_we = 0 immediately and empty = 1. With STORE_BUFFER_STATS_EN defined, the counters clear to 0.

Source files
------------

// File: rtl/store_buffer_if.sv
// Bundle of the store_buffer's core-facing store/load handshake and memory-port signals.
// master = MEM stage / test driver, slave = store_buffer.
interface store_buffer_if #(
  parameter int WIDTH = 32
);
  logic             st_valid;
  logic [WIDTH-1:0] st_addr;
  logic [WIDTH-1:0] st_data;
  logic [2:0]       st_mode;
  logic             st_ready;

  logic             ld_valid;
  logic [WIDTH-1:0] ld_addr;
  logic [2:0]       ld_mode;
  logic             ld_stall;

  logic             flush;
  logic             empty;

  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wd;
  logic [2:0]       mem_mode;

  modport master (
    output st_valid, st_addr, st_data, st_mode,
    input  st_ready,
    output ld_valid, ld_addr, ld_mode,
    input  ld_stall,
    output flush,
    input  empty,
    input  mem_we, mem_addr, mem_wd, mem_mode
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_mode,
    output st_ready,
    input  ld_valid, ld_addr, ld_mode,
    output ld_stall,
    input  flush,
    output empty,
    output mem_we, mem_addr, mem_wd, mem_mode
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-store FIFO in front of a single-port data memory; loads overlapping a pending store stall.
// Optional STORE_BUFFER_STATS_EN adds saturating stall_cnt / drain_cnt outputs.
// Handshake: a store is pushed on a rising edge where st_valid & st_ready; a load proceeds in any cycle with ld_stall = 0.
module store_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  store_buffer_if.slave bus
`ifdef STORE_BUFFER_STATS_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   drain_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]    FULL      = CW'(DEPTH);
  localparam logic [WIDTH-1:0] MMIO_ADDR = WIDTH'(32'h100);

  logic [WIDTH-1:0] r_addr [DEPTH];
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [2:0]       r_mode [DEPTH];
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  logic             w_empty;
  logic             w_push;
  logic             w_drain;
  logic             w_hazard;
  logic             w_mmio;
  logic [DEPTH-1:0] w_hit;
  logic [17:0]      w_ld_lo;
  logic [17:0]      w_ld_hi;

  function automatic logic [17:0] size_bytes(input logic [2:0] mode);
    case (mode)
      3'b001:         size_bytes = 18'd4;
      3'b010, 3'b100: size_bytes = 18'd2;
      default:        size_bytes = 18'd1;
    endcase
  endfunction

  // Overlap uses the low 17 address bits widened to 18 so a range end never wraps.
  assign w_ld_lo = {1'b0, bus.ld_addr[16:0]};
  assign w_ld_hi = w_ld_lo + size_bytes(bus.ld_mode) - 18'd1;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [AW-1:0] w_off;
    logic [17:0]   w_st_lo;
    logic [17:0]   w_st_hi;
    assign w_off    = AW'(g) - r_head;
    assign w_st_lo  = {1'b0, r_addr[g][16:0]};
    assign w_st_hi  = w_st_lo + size_bytes(r_mode[g]) - 18'd1;
    assign w_hit[g] = ({1'b0, w_off} < r_count) &&
                      (w_ld_lo <= w_st_hi) && (w_st_lo <= w_ld_hi);
  end

  // The trigger register is exempt from overlap, but a fence still holds every load.
  assign w_mmio   = (bus.ld_addr == MMIO_ADDR);
  assign w_empty  = (r_count == '0);
  assign w_hazard = bus.ld_valid & (((|w_hit) & ~w_mmio) | bus.flush) & ~w_empty;
  assign w_drain  = ~w_empty & (~bus.ld_valid | w_hazard);
  assign w_push   = bus.st_valid & bus.st_ready;

  assign bus.st_ready = (r_count != FULL) & ~bus.flush;
  assign bus.empty    = w_empty;
  assign bus.ld_stall = w_hazard;

  always_comb begin
    bus.mem_we   = 1'b0;
    bus.mem_addr = bus.ld_addr;
    bus.mem_wd   = '0;
    bus.mem_mode = bus.ld_mode;
    if (w_drain) begin
      bus.mem_we   = 1'b1;
      bus.mem_addr = r_addr[r_head];
      bus.mem_wd   = r_data[r_head];
      bus.mem_mode = r_mode[r_head];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)  r_tail <= r_tail + 1'b1;
      if (w_drain) r_head <= r_head + 1'b1;
      case ({w_push, w_drain})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset: a slot is only read while the count marks it valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= bus.st_addr;
      r_data[r_tail] <= bus.st_data;
      r_mode[r_tail] <= bus.st_mode;
    end
  end

`ifdef STORE_BUFFER_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_drain_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (w_hazard && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_drain  && (r_drain_cnt != 32'hFFFF_FFFF)) r_drain_cnt <= r_drain_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign drain_cnt = r_drain_cnt;
`endif
endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: push/drain, fill, hazards, MMIO exemption, flush, async reset.
module tb_store_buffer;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] e_addr;
  logic [31:0] e_data;

  store_buffer_if #(.WIDTH(32)) sb_if ();

`ifdef STORE_BUFFER_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] drain_cnt;
`endif

  store_buffer #(.WIDTH(32), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (sb_if)
`ifdef STORE_BUFFER_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .drain_cnt (drain_cnt)
`endif
  );

  // Clock/reset: posedges at 5, 15, ...; inputs change on negedges.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    sb_if.st_valid = 1'b0;
    sb_if.st_addr  = '0;
    sb_if.st_data  = '0;
    sb_if.st_mode  = 3'b000;
    sb_if.ld_valid = 1'b0;
    sb_if.ld_addr  = '0;
    sb_if.ld_mode  = 3'b000;
    sb_if.flush    = 1'b0;
  endtask

  task automatic set_store(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [2:0] m);
    sb_if.st_valid = v;
    sb_if.st_addr  = a;
    sb_if.st_data  = d;
    sb_if.st_mode  = m;
  endtask

  task automatic set_load(input logic v, input logic [31:0] a, input logic [2:0] m);
    sb_if.ld_valid = v;
    sb_if.ld_addr  = a;
    sb_if.ld_mode  = m;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    check("reset_st_ready", {31'd0, sb_if.st_ready}, 32'd1);
    check("reset_empty",    {31'd0, sb_if.empty},    32'd1);
    check("reset_ld_stall", {31'd0, sb_if.ld_stall}, 32'd0);
    check("reset_mem_we",   {31'd0, sb_if.mem_we},   32'd0);
`ifdef STORE_BUFFER_STATS_EN
    check("reset_stall_cnt", stall_cnt, 32'd0);
    check("reset_drain_cnt", drain_cnt, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Single push then idle: written to memory the cycle after the push.
    set_store(1'b1, 32'h40, 32'h1122_3344, 3'b001);
    #1;
    check("push_no_we", {31'd0, sb_if.mem_we}, 32'd0);
    next_cycle();
    set_store(1'b0, 32'h0, 32'h0, 3'b000);
    #1;
    check("push_we",    {31'd0, sb_if.mem_we},  32'd1);
    check("push_addr",  sb_if.mem_addr,          32'h40);
    check("push_wd",    sb_if.mem_wd,            32'h1122_3344);
    check("push_mode",  {29'd0, sb_if.mem_mode}, 32'd1);
    check("push_busy",  {31'd0, sb_if.empty},    32'd0);
    next_cycle();
    check("push_empty", {31'd0, sb_if.empty},    32'd1);
    check("push_idle_we", {31'd0, sb_if.mem_we}, 32'd0);

    // Fill four entries while a non-overlapping load holds the port.
    set_load(1'b1, 32'h200, 3'b001);
    for (int i = 0; i < 4; i++) begin
      e_addr = 32'h10 + 32'(4 * i);
      e_data = 32'hA000_0000 + 32'(i);
      set_store(1'b1, e_addr, e_data, 3'b001);
      exp_addr_q.push_back(e_addr);
      exp_data_q.push_back(e_data);
      #1;
      check("fill_stall", {31'd0, sb_if.ld_stall}, 32'd0);
      check("fill_we",    {31'd0, sb_if.mem_we},   32'd0);
      next_cycle();
    end
    set_store(1'b0, 32'h0, 32'h0, 3'b000);
    #1;
    check("full_ready", {31'd0, sb_if.st_ready}, 32'd0);
    check("full_stall", {31'd0, sb_if.ld_stall}, 32'd0);
    check("full_addr",  sb_if.mem_addr,          32'h200);
    set_load(1'b0, 32'h0, 3'b000);
    #1;
    for (int i = 0; i < 4; i++) begin
      e_addr = exp_addr_q.pop_front();
      e_data = exp_data_q.pop_front();
      check("drain_we",   {31'd0, sb_if.mem_we}, 32'd1);
      check("drain_addr", sb_if.mem_addr,         e_addr);
      check("drain_wd",   sb_if.mem_wd,           e_data);
      if (i == 0) check("drain_full_ready", {31'd0, sb_if.st_ready}, 32'd0);
      if (i == 1) check("drain_ready_back", {31'd0, sb_if.st_ready}, 32'd1);
      next_cycle();
    end
    check("drain_empty", {31'd0, sb_if.empty}, 32'd1);

    // Byte store at 0x43 overlaps a word load at 0x40.
    set_store(1'b1, 32'h43, 32'hAB, 3'b011);
    next_cycle();
    set_store(1'b0, 32'h0, 32'h0, 3'b000);
    set_load(1'b1, 32'h40, 3'b001);
    #1;
    check("haz_stall", {31'd0, sb_if.ld_stall}, 32'd1);
    check("haz_we",    {31'd0, sb_if.mem_we},   32'd1);
    check("haz_addr",  sb_if.mem_addr,           32'h43);
    check("haz_mode",  {29'd0, sb_if.mem_mode},  32'd3);
    next_cycle();
    check("haz_clear",     {31'd0, sb_if.ld_stall}, 32'd0);
    check("haz_ld_addr",   sb_if.mem_addr,           32'h40);
    check("haz_ld_we",     {31'd0, sb_if.mem_we},   32'd0);
    set_load(1'b0, 32'h0, 3'b000);

    // Half at 0x44 covers 0x44..0x45: 0x46 is clear, 0x45 is the boundary hit.
    set_store(1'b1, 32'h44, 32'h5566, 3'b010);
    next_cycle();
    set_store(1'b0, 32'h0, 32'h0, 3'b000);
    set_load(1'b1, 32'h46, 3'b011);
    #1;
    check("nohaz_stall", {31'd0, sb_if.ld_stall}, 32'd0);
    check("nohaz_addr",  sb_if.mem_addr,           32'h46);
    set_load(1'b1, 32'h45, 3'b011);
    #1;
    check("edge_stall", {31'd0, sb_if.ld_stall}, 32'd1);
    check("edge_addr",  sb_if.mem_addr,           32'h44);
    next_cycle();
    set_load(1'b0, 32'h0, 3'b000);
    #1;
    check("edge_empty", {31'd0, sb_if.empty}, 32'd1);

    // Word at 0xFE spans 0xFE..0x101; only the trigger address is exempt.
    set_store(1'b1, 32'hFE, 32'hCAFE_F00D, 3'b001);
    next_cycle();
    set_store(1'b0, 32'h0, 32'h0, 3'b000);
    set_load(1'b1, 32'h100, 3'b001);
    #1;
    check("mmio_stall", {31'd0, sb_if.ld_stall}, 32'd0);
    check("mmio_we",    {31'd0, sb_if.mem_we},   32'd0);
    set_load(1'b1, 32'h101, 3'b011);
    #1;
    check("mmio_nb_stall", {31'd0, sb_if.ld_stall}, 32'd1);
    next_cycle();
    set_load(1'b0, 32'h0, 3'b000);
    #1;
    check("mmio_empty", {31'd0, sb_if.empty}, 32'd1);

    // Flush: three pending entries drain back to back; pushes and loads are held.
    set_load(1'b1, 32'h200, 3'b001);
    for (int i = 0; i < 3; i++) begin
      e_addr = 32'h300 + 32'(4 * i);
      e_data = 32'hF000_0000 + 32'(i);
      set_store(1'b1, e_addr, e_data, 3'b001);
      exp_addr_q.push_back(e_addr);
      exp_data_q.push_back(e_data);
      next_cycle();
    end
    sb_if.flush = 1'b1;
    set_store(1'b1, 32'h500, 32'hDEAD_BEEF, 3'b001);
    #1;
    for (int i = 0; i < 3; i++) begin
      e_addr = exp_addr_q.pop_front();
      e_data = exp_data_q.pop_front();
      check("flush_ready", {31'd0, sb_if.st_ready}, 32'd0);
      check("flush_stall", {31'd0, sb_if.ld_stall}, 32'd1);
      check("flush_we",    {31'd0, sb_if.mem_we},   32'd1);
      check("flush_addr",  sb_if.mem_addr,           e_addr);
      check("flush_wd",    sb_if.mem_wd,             e_data);
      next_cycle();
    end
    check("flush_empty",    {31'd0, sb_if.empty},    32'd1);
    check("flush_no_stall", {31'd0, sb_if.ld_stall}, 32'd0);
    check("flush_no_we",    {31'd0, sb_if.mem_we},   32'd0);
    sb_if.flush = 1'b0;
    set_store(1'b0, 32'h0, 32'h0, 3'b000);
    set_load(1'b0, 32'h0, 3'b000);

`ifdef STORE_BUFFER_STATS_EN
    // Stalls: hazard 1 + boundary 1 + MMIO neighbour 1 + flush 3; drains: 1 + 4 + 1 + 1 + 1 + 3.
    #1;
    check("stats_stall", stall_cnt, 32'd6);
    check("stats_drain", drain_cnt, 32'd11);
`endif

    // Async reset with two pending entries while the first is on the port.
    set_load(1'b1, 32'h200, 3'b001);
    set_store(1'b1, 32'h600, 32'h1, 3'b001);
    next_cycle();
    set_store(1'b1, 32'h604, 32'h2, 3'b001);
    next_cycle();
    set_store(1'b0, 32'h0, 32'h0, 3'b000);
    set_load(1'b0, 32'h0, 3'b000);
    #1;
    check("pre_rst_we", {31'd0, sb_if.mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_we",    {31'd0, sb_if.mem_we},   32'd0);
    check("rst_empty", {31'd0, sb_if.empty},    32'd1);
    check("rst_ready", {31'd0, sb_if.st_ready}, 32'd1);
`ifdef STORE_BUFFER_STATS_EN
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_drain_cnt", drain_cnt, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    check("post_rst_empty", {31'd0, sb_if.empty},  32'd1);
    check("post_rst_we",    {31'd0, sb_if.mem_we}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
